aes_ctr_sched: RTL

- Sequences AES counter (CTR) mode keystream generation for N consecutive blocks.
- For each block it presents the current counter value to the cipher core through a valid/ready handshake. It then requests one increment from the counter-increment unit using the sparse 3-bit increment/ready handshake, and waits for that increment to complete before issuing the next block.
- Sits between the main control FSM (start/done), the IV/counter register, the counter-increment unit and the cipher core input.

---
 rtl/aes_ctr_sched.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/aes_ctr_sched.sv
// aes_ctr_sched: sequences AES-CTR keystream generation over N consecutive blocks.
// For every block the current counter is offered to the cipher core through a
// valid/ready handshake. One increment is then requested from the counter unit
// over a sparse 3-bit handshake, and the next block is issued only after that
// increment has completed.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   start_i, num_blocks_i  start request and block count (sampled in IDLE only)
//   ctr_i                  current counter from the IV/counter register
//   blk_valid_o/ready_i    counter block handshake toward the cipher core
//   blk_data_o             counter block (ctr_i while valid, zero otherwise)
//   ctr_incr_o             sparse increment request (HIGH=3'b011, LOW=3'b100)
//   ctr_ready_i            sparse ready from the counter unit, same encoding
//   ctr_alert_i            alert from the counter unit
//   busy_o                 high in any state other than IDLE
//   done_o                 one-cycle completion pulse
//   remaining_o            blocks still to be issued
//   alert_o                sticky fatal alert
module aes_ctr_sched #(
    parameter int unsigned CtrWidth = 128,
    parameter int unsigned LenWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [LenWidth-1:0] num_blocks_i,
    input  logic [CtrWidth-1:0] ctr_i,
    output logic                blk_valid_o,
    input  logic                blk_ready_i,
    output logic [CtrWidth-1:0] blk_data_o,
    output logic [2:0]          ctr_incr_o,
    input  logic [2:0]          ctr_ready_i,
    input  logic                ctr_alert_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [LenWidth-1:0] remaining_o,
    output logic                alert_o
);

    // Sparse handshake encoding shared by the increment request and ready.
    localparam logic [2:0] IncrHigh = 3'b011;
    localparam logic [2:0] IncrLow  = 3'b100;

    typedef enum logic [2:0] {
        StIdle  = 3'b000,
        StIssue = 3'b001,
        StIncr  = 3'b010,
        StWait  = 3'b011,
        StError = 3'b100
    } state_e;

    state_e                state_q,      state_d;
    logic [LenWidth-1:0]   remaining_q,  remaining_d;
    logic                  done_q,       done_d;
    logic                  alert_q,      alert_d;
    logic                  wait_first_q, wait_first_d;

    logic                  ready_high_c;
    logic                  fault_c;

    // Counter-unit status decode: anything outside the two legal codes is a fault.
    assign ready_high_c = (ctr_ready_i == IncrHigh);
    assign fault_c      = ctr_alert_i ||
                          !((ctr_ready_i == IncrHigh) || (ctr_ready_i == IncrLow));

    // State and status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            done_q       <= 1'b0;
            alert_q      <= 1'b0;
            wait_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            done_q       <= done_d;
            alert_q      <= alert_d;
            wait_first_q <= wait_first_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        done_d       = 1'b0;
        alert_d      = alert_q;
        wait_first_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (num_blocks_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        remaining_d = num_blocks_i;
                        state_d     = StIssue;
                    end
                end
            end

            StIssue: begin
                // Valid is implied by the state; only the cipher's ready matters.
                if (blk_ready_i) begin
                    remaining_d = remaining_q - LenWidth'(1);
                    state_d     = StIncr;
                end
            end

            StIncr: begin
                if (ready_high_c) begin
                    state_d      = StWait;
                    wait_first_d = 1'b1;
                end
            end

            StWait: begin
                // The counter unit still shows its pre-accept ready in the
                // first WAIT cycle, so that cycle is never an exit.
                if (!wait_first_q && ready_high_c) begin
                    if (remaining_q != '0) begin
                        state_d = StIssue;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end

            StError: begin
                state_d = StError;
            end

            default: begin
                state_d = StError;
                alert_d = 1'b1;
            end
        endcase

        // A fault outranks any handshake completing in the same cycle.
        if ((state_q != StError) && fault_c) begin
            state_d      = StError;
            alert_d      = 1'b1;
            remaining_d  = remaining_q;
            done_d       = 1'b0;
            wait_first_d = 1'b0;
        end
    end

    // Outputs decoded from the state register; block data follows ctr_i while valid.
    assign blk_valid_o = (state_q == StIssue);
    assign blk_data_o  = (state_q == StIssue) ? ctr_i : '0;
    assign ctr_incr_o  = (state_q == StIncr) ? IncrHigh : IncrLow;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign remaining_o = remaining_q;
    assign alert_o     = alert_q;

endmodule
